// File: rtl/shift_chain_sequencer.sv
// Loopback/transport engine for an external serial shift-register chain.
// Sends a word LSB-first, recovers it from the chain tail, flags mismatch.
module shift_chain_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             sr_d,
    output logic             sr_en,
    input  logic             sr_q,
    output logic             busy,
    output logic [WIDTH-1:0] dout,
    output logic             done,
    output logic             err
);

    localparam int TOTAL = WIDTH + DEPTH;
    localparam int CW    = $clog2(TOTAL + 1);

    localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
    localparam logic [CW-1:0] CAP_FROM = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] tx;
    logic [WIDTH-1:0] tx_sh;
    logic [WIDTH-1:0] cap;
    logic [WIDTH:0]   cap_ext;
    logic [WIDTH-1:0] cap_next;
    logic             unused_cap_lsb;

    // Chain output enters at the MSB; the oldest bit ends up at bit 0.
    assign cap_ext        = {sr_q, cap};
    assign cap_next       = cap_ext[WIDTH:1];
    assign unused_cap_lsb = cap_ext[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            tx    <= '0;
            tx_sh <= '0;
            cap   <= '0;
            sr_d  <= 1'b0;
            sr_en <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dout  <= '0;
            err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    sr_d  <= 1'b0;
                    sr_en <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        state <= SHIFT;
                        tx    <= din;
                        tx_sh <= din >> 1;
                        cnt   <= '0;
                        cap   <= '0;
                        sr_d  <= din[0];
                        sr_en <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt >= CAP_FROM) begin
                        cap <= cap_next;
                    end
                    // tx_sh drains to zero, which supplies the flush bits.
                    if (cnt == LAST) begin
                        state <= DONE;
                        sr_d  <= 1'b0;
                        sr_en <= 1'b0;
                        done  <= 1'b1;
                        dout  <= cap_next;
                        err   <= (cap_next != tx);
                    end else begin
                        sr_d  <= tx_sh[0];
                        tx_sh <= tx_sh >> 1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    sr_d  <= 1'b0;
                    sr_en <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
